// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm clock: FSM mode codes and time-field limits.
// Imported by the setting controller, the timekeeper and the display.
package alarm_pkg;

  typedef enum logic [2:0] {
    MODE_RUN  = 3'd0,
    MODE_T_HH = 3'd1,
    MODE_T_MM = 3'd2,
    MODE_A_HH = 3'd3,
    MODE_A_MM = 3'd4
  } mode_e;

  localparam int unsigned HH_MAX = 23;
  localparam int unsigned MM_MAX = 59;
  localparam int unsigned HH_W   = 5;
  localparam int unsigned MM_W   = 6;

  function automatic logic is_hh_field(input mode_e m);
    return (m == MODE_T_HH) || (m == MODE_A_HH);
  endfunction

  function automatic logic is_mm_field(input mode_e m);
    return (m == MODE_T_MM) || (m == MODE_A_MM);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Loadable up/down counter that wraps over 0..MAX; holds when inc and dec coincide.
module wrap_counter #(
  parameter int unsigned MAX = 23,
  parameter int unsigned W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] val_q, val_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = load_val;
    end else if (inc && !dec) begin
      val_d = (val_q >= MAX_V) ? '0 : val_q + W'(1);
    end else if (dec && !inc) begin
      val_d = (val_q == '0) ? MAX_V : val_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign value = val_q;

endmodule

// File: rtl/alarm_set_ctrl.sv
// Mode/setting controller: sequences time and alarm editing, owns the committed alarm,
// strobes load_time to the timekeeper, and generates the edit-field blink phase.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 10000,
  parameter int unsigned BLINK_TICKS   = 250
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick_mf,
  input  logic            btn_mode,
  input  logic            btn_up,
  input  logic            btn_down,
  input  logic [HH_W-1:0] cur_hh,
  input  logic [MM_W-1:0] cur_mm,
  output logic [2:0]      mode,
  output logic [HH_W-1:0] edit_hh,
  output logic [MM_W-1:0] edit_mm,
  output logic            load_time,
  output logic [HH_W-1:0] alarm_hh,
  output logic [MM_W-1:0] alarm_mm,
  output logic            alarm_en,
  output logic            blink_on
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int unsigned BL_W = $clog2(BLINK_TICKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_TICKS - 1);

  mode_e           mode_q, mode_d;
  logic            load_time_q, load_time_d;
  logic [HH_W-1:0] alarm_hh_q, alarm_hh_d;
  logic [MM_W-1:0] alarm_mm_q, alarm_mm_d;
  logic            alarm_en_q, alarm_en_d;
  logic            blink_q, blink_d;
  logic [BL_W-1:0] bcnt_q, bcnt_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;

  // Mode beats up/down; up+down together is a no-op that still counts as activity.
  logic up_p, dn_p, any_btn, in_set;
  assign up_p    = btn_up   && !btn_down && !btn_mode;
  assign dn_p    = btn_down && !btn_up   && !btn_mode;
  assign any_btn = btn_mode || btn_up || btn_down;
  assign in_set  = (mode_q != MODE_RUN);

  // Edit buffer takes the live time on entry to T_HH and the committed alarm
  // in the cycle after the load_time strobe.
  logic            edit_load;
  logic [HH_W-1:0] hh_load_val;
  logic [MM_W-1:0] mm_load_val;
  assign edit_load   = ((mode_q == MODE_RUN) && btn_mode) || load_time_q;
  assign hh_load_val = (mode_q == MODE_RUN) ? cur_hh : alarm_hh_q;
  assign mm_load_val = (mode_q == MODE_RUN) ? cur_mm : alarm_mm_q;

  wrap_counter #(.MAX(HH_MAX), .W(HH_W)) u_hh (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (is_hh_field(mode_q) && up_p),
    .dec      (is_hh_field(mode_q) && dn_p),
    .load     (edit_load),
    .load_val (hh_load_val),
    .value    (edit_hh)
  );

  wrap_counter #(.MAX(MM_MAX), .W(MM_W)) u_mm (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (is_mm_field(mode_q) && up_p),
    .dec      (is_mm_field(mode_q) && dn_p),
    .load     (edit_load),
    .load_val (mm_load_val),
    .value    (edit_mm)
  );

  always_comb begin
    mode_d      = mode_q;
    load_time_d = 1'b0;
    alarm_hh_d  = alarm_hh_q;
    alarm_mm_d  = alarm_mm_q;
    alarm_en_d  = alarm_en_q;
    blink_d     = blink_q;
    bcnt_d      = bcnt_q;
    tcnt_d      = tcnt_q;

    unique case (mode_q)
      MODE_RUN: begin
        if (btn_mode)  mode_d = MODE_T_HH;
        else if (up_p) alarm_en_d = !alarm_en_q;
      end
      MODE_T_HH: if (btn_mode) mode_d = MODE_T_MM;
      MODE_T_MM: begin
        if (btn_mode) begin
          mode_d      = MODE_A_HH;
          load_time_d = 1'b1;
        end
      end
      MODE_A_HH: if (btn_mode) mode_d = MODE_A_MM;
      MODE_A_MM: begin
        if (btn_mode) begin
          mode_d     = MODE_RUN;
          alarm_hh_d = edit_hh;
          alarm_mm_d = edit_mm;
          alarm_en_d = 1'b1;
        end
      end
      default: mode_d = MODE_RUN;
    endcase

    if (in_set) begin
      // A button in the expiry cycle clears the count instead of aborting.
      if (any_btn) begin
        tcnt_d = '0;
      end else if (tick_mf) begin
        if (tcnt_q == TO_LAST) begin
          mode_d = MODE_RUN;
          tcnt_d = '0;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end

      if (any_btn) begin
        blink_d = 1'b1;
        bcnt_d  = '0;
      end else if (tick_mf) begin
        if (bcnt_q == BL_LAST) begin
          blink_d = !blink_q;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + BL_W'(1);
        end
      end
    end

    if (mode_d == MODE_RUN) begin
      tcnt_d  = '0;
      bcnt_d  = '0;
      blink_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_RUN;
      load_time_q <= 1'b0;
      alarm_hh_q  <= '0;
      alarm_mm_q  <= '0;
      alarm_en_q  <= 1'b0;
      blink_q     <= 1'b1;
      bcnt_q      <= '0;
      tcnt_q      <= '0;
    end else begin
      mode_q      <= mode_d;
      load_time_q <= load_time_d;
      alarm_hh_q  <= alarm_hh_d;
      alarm_mm_q  <= alarm_mm_d;
      alarm_en_q  <= alarm_en_d;
      blink_q     <= blink_d;
      bcnt_q      <= bcnt_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign mode      = mode_q;
  assign load_time = load_time_q;
  assign alarm_hh  = alarm_hh_q;
  assign alarm_mm  = alarm_mm_q;
  assign alarm_en  = alarm_en_q;
  assign blink_on  = blink_q;

endmodule
